// File: rtl/rtc_calendar_core.sv
// Real-time clock/calendar core: prescaled 1 Hz tick driving sec..year counters
// with leap years, field set/increment strobes and an hour:minute alarm.
module rtc_calendar_core #(
  parameter int TICK_DIV = 32768,
  parameter int YEAR_MAX = 99
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_run,
  input  logic       i_set_valid,
  input  logic [2:0] i_set_field,
  input  logic [6:0] i_set_value,
  input  logic       i_inc_valid,
  input  logic [2:0] i_inc_field,
  input  logic       i_alarm_en,
  input  logic [4:0] i_alarm_hour,
  input  logic [5:0] i_alarm_minute,
  input  logic       i_alarm_clr,
  output logic [5:0] o_second,
  output logic [5:0] o_minute,
  output logic [4:0] o_hour,
  output logic [4:0] o_day,
  output logic [3:0] o_month,
  output logic [6:0] o_year,
  output logic       o_sec_pulse,
  output logic       o_alarm_irq,
  output logic       o_alarm_pending
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0]    YMAX       = 7'(YEAR_MAX);

  localparam logic [2:0] F_SEC  = 3'd0;
  localparam logic [2:0] F_MIN  = 3'd1;
  localparam logic [2:0] F_HOUR = 3'd2;
  localparam logic [2:0] F_DAY  = 3'd3;
  localparam logic [2:0] F_MON  = 3'd4;
  localparam logic [2:0] F_YEAR = 3'd5;

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic [6:0] y);
    case (m)
      4'd2:                    month_len = (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
      default:                 month_len = 5'd31;
    endcase
  endfunction

  logic [PW-1:0] r_presc;
  logic          r_defer;
  logic [5:0]    r_second;
  logic [5:0]    r_minute;
  logic [4:0]    r_hour;
  logic [4:0]    r_day;
  logic [3:0]    r_month;
  logic [6:0]    r_year;
  logic          r_sec_pulse;
  logic          r_alarm_irq;
  logic          r_alarm_pending;
  logic          r_match_d;

  logic       w_tick;
  logic       w_upd;
  logic       w_do_tick;
  logic       w_sec_loaded;
  logic       w_match;
  logic       w_irq_nx;
  logic [4:0] w_mlen;
  logic [4:0] w_new_mlen;
  logic [5:0] w_sec_nx;
  logic [5:0] w_min_nx;
  logic [4:0] w_hour_nx;
  logic [4:0] w_day_nx;
  logic [3:0] w_mon_nx;
  logic [6:0] w_year_nx;

  // Strobes are single-cycle requests with no back-pressure: any cycle carrying
  // set_valid or inc_valid owns the field update and pushes the tick into r_defer.
  assign w_tick    = i_run && (r_presc == PRESC_LAST);
  assign w_upd     = i_set_valid || i_inc_valid;
  assign w_do_tick = !w_upd && i_run && (w_tick || r_defer);
  assign w_mlen    = month_len(r_month, r_year);

  always_comb begin
    w_sec_nx     = r_second;
    w_min_nx     = r_minute;
    w_hour_nx    = r_hour;
    w_day_nx     = r_day;
    w_mon_nx     = r_month;
    w_year_nx    = r_year;
    w_sec_loaded = 1'b0;
    w_new_mlen   = 5'd31;
    if (i_set_valid) begin
      case (i_set_field)
        F_SEC:  if (i_set_value <= 7'd59) begin
                  w_sec_nx     = i_set_value[5:0];
                  w_sec_loaded = 1'b1;
                end
        F_MIN:  if (i_set_value <= 7'd59) w_min_nx = i_set_value[5:0];
        F_HOUR: if (i_set_value <= 7'd23) w_hour_nx = i_set_value[4:0];
        F_DAY:  if (i_set_value >= 7'd1 && i_set_value <= {2'b00, w_mlen}) w_day_nx = i_set_value[4:0];
        F_MON:  if (i_set_value >= 7'd1 && i_set_value <= 7'd12) w_mon_nx = i_set_value[3:0];
        F_YEAR: if (i_set_value <= YMAX) w_year_nx = i_set_value;
        default: ;
      endcase
    end else if (i_inc_valid) begin
      case (i_inc_field)
        F_SEC:  w_sec_nx  = (r_second == 6'd59) ? 6'd0 : r_second + 6'd1;
        F_MIN:  w_min_nx  = (r_minute == 6'd59) ? 6'd0 : r_minute + 6'd1;
        F_HOUR: w_hour_nx = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
        F_DAY:  w_day_nx  = (r_day >= w_mlen) ? 5'd1 : r_day + 5'd1;
        F_MON:  w_mon_nx  = (r_month == 4'd12) ? 4'd1 : r_month + 4'd1;
        F_YEAR: w_year_nx = (r_year >= YMAX) ? 7'd0 : r_year + 7'd1;
        default: ;
      endcase
    end else if (w_do_tick) begin
      if (r_second != 6'd59) w_sec_nx = r_second + 6'd1;
      else begin
        w_sec_nx = 6'd0;
        if (r_minute != 6'd59) w_min_nx = r_minute + 6'd1;
        else begin
          w_min_nx = 6'd0;
          if (r_hour != 5'd23) w_hour_nx = r_hour + 5'd1;
          else begin
            w_hour_nx = 5'd0;
            if (r_day != w_mlen) w_day_nx = r_day + 5'd1;
            else begin
              w_day_nx = 5'd1;
              if (r_month != 4'd12) w_mon_nx = r_month + 4'd1;
              else begin
                w_mon_nx  = 4'd1;
                w_year_nx = (r_year >= YMAX) ? 7'd0 : r_year + 7'd1;
              end
            end
          end
        end
      end
    end
    // A new month or year may be shorter than the current day; pin to its last day.
    w_new_mlen = month_len(w_mon_nx, w_year_nx);
    if (w_day_nx > w_new_mlen) w_day_nx = w_new_mlen;
  end

  assign w_match  = i_alarm_en && (r_hour == i_alarm_hour) &&
                    (r_minute == i_alarm_minute) && (r_second == 6'd0);
  assign w_irq_nx = w_match && !r_match_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_presc         <= '0;
      r_defer         <= 1'b0;
      r_second        <= 6'd0;
      r_minute        <= 6'd0;
      r_hour          <= 5'd0;
      r_day           <= 5'd1;
      r_month         <= 4'd1;
      r_year          <= 7'd0;
      r_sec_pulse     <= 1'b0;
      r_alarm_irq     <= 1'b0;
      r_alarm_pending <= 1'b0;
      r_match_d       <= 1'b0;
    end else begin
      if (w_sec_loaded)  r_presc <= '0;
      else if (i_run)    r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_sec_loaded)  r_defer <= 1'b0;
      else if (w_upd)    r_defer <= r_defer | w_tick;
      else if (i_run)    r_defer <= 1'b0;
      r_second        <= w_sec_nx;
      r_minute        <= w_min_nx;
      r_hour          <= w_hour_nx;
      r_day           <= w_day_nx;
      r_month         <= w_mon_nx;
      r_year          <= w_year_nx;
      r_sec_pulse     <= w_do_tick;
      r_alarm_irq     <= w_irq_nx;
      r_alarm_pending <= w_irq_nx | (r_alarm_pending & ~i_alarm_clr);
      r_match_d       <= w_match;
    end
  end

  assign o_second        = r_second;
  assign o_minute        = r_minute;
  assign o_hour          = r_hour;
  assign o_day           = r_day;
  assign o_month         = r_month;
  assign o_year          = r_year;
  assign o_sec_pulse     = r_sec_pulse;
  assign o_alarm_irq     = r_alarm_irq;
  assign o_alarm_pending = r_alarm_pending;

endmodule
